// File: rtl/spike_dispatcher_if.sv
// Spike stream from the dispatcher to the MAC units: addresses plus the end-of-timestep clear.
// Valid/ready: a spike transfers on a rising edge where spike_valid && spike_ready are both high.
// Once spike_valid rises, it and source_address are held until that transfer happens.
// spike_ready is ignored while spike_valid is low.
interface spike_dispatcher_if #(
  parameter int number_of_address_bits = 12
);
  logic                              spike_valid;
  logic [number_of_address_bits-1:0] source_address;
  logic                              spike_ready;
  logic                              clear;

  modport master (output spike_valid, output source_address, output clear, input spike_ready);
  modport slave  (input spike_valid, input source_address, input clear, output spike_ready);
endinterface

// File: rtl/spike_dispatcher.sv
// Latches a fired-spike vector each timestep and streams one source address per handshake, then pulses clear.
// Optional macro SPIKE_DISPATCH_COUNT_EN adds a per-timestep transfer counter output, spike_count.
module spike_dispatcher #(
  parameter int number_of_units        = 10,
  parameter int number_of_address_bits = 12
) (
  input  logic                              CLK,
  input  logic                              reset,
  input  logic [number_of_address_bits-1:0] base_address,
  input  logic                              timestep_done,
  input  logic [number_of_units-1:0]        spikes_in,
  spike_dispatcher_if.master                bus,
  output logic                              busy,
  output logic                              overrun,
  output logic [1:0]                        fsm_state
`ifdef SPIKE_DISPATCH_COUNT_EN
  ,
  output logic [15:0]                       spike_count
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam logic [number_of_units-1:0] unit_one = number_of_units'(1);

  state_t                            state, state_next;
  logic [number_of_units-1:0]        pending, pending_next, rest;
  logic [number_of_address_bits-1:0] base, base_next;
  logic [number_of_address_bits-1:0] addr, addr_next;
  logic                              valid, valid_next;
  logic                              clear_q, clear_next;
  logic                              busy_q;
  logic                              overrun_q, overrun_next;
  logic                              xfer;

  function automatic logic [number_of_address_bits-1:0] lowest_index(
    input logic [number_of_units-1:0] v
  );
    lowest_index = '0;
    for (int i = number_of_units - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = number_of_address_bits'(i);
    end
  endfunction

  assign xfer = valid & bus.spike_ready;
  // Pending with its lowest set bit (the spike being transferred) removed.
  assign rest = pending & (pending - unit_one);

  always_ff @(posedge CLK) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (timestep_done) state_next = (spikes_in != '0) ? SEND : CLEAR;
      SEND:    if (xfer && (rest == '0)) state_next = CLEAR;
      CLEAR:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pending_next = pending;
    base_next    = base;
    addr_next    = addr;
    valid_next   = valid;
    clear_next   = 1'b0;
    overrun_next = overrun_q | (timestep_done & (state != IDLE));
    case (state)
      IDLE: begin
        if (timestep_done) begin
          pending_next = spikes_in;
          base_next    = base_address;
          valid_next   = (spikes_in != '0);
          clear_next   = (spikes_in == '0);
          if (spikes_in != '0) addr_next = base_address + lowest_index(spikes_in);
        end
      end
      SEND: begin
        // Next address is precomputed so a held-high ready gets one spike per cycle.
        if (xfer) begin
          pending_next = rest;
          valid_next   = (rest != '0);
          clear_next   = (rest == '0);
          if (rest != '0) addr_next = base + lowest_index(rest);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      pending   <= '0;
      base      <= '0;
      addr      <= '0;
      valid     <= 1'b0;
      clear_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      pending   <= pending_next;
      base      <= base_next;
      addr      <= addr_next;
      valid     <= valid_next;
      clear_q   <= clear_next;
      busy_q    <= (state_next != IDLE);
      overrun_q <= overrun_next;
    end
  end

  assign bus.spike_valid    = valid;
  assign bus.source_address = addr;
  assign bus.clear          = clear_q;
  assign busy               = busy_q;
  assign overrun            = overrun_q;
  assign fsm_state          = state;

`ifdef SPIKE_DISPATCH_COUNT_EN
  logic [15:0] count_q;

  always_ff @(posedge CLK) begin
    if (reset)                                    count_q <= '0;
    else if (timestep_done && (state == IDLE))    count_q <= '0;
    else if (xfer && (count_q != 16'hFFFF))       count_q <= count_q + 16'd1;
  end

  assign spike_count = count_q;
`endif

endmodule

// File: tb/tb_spike_dispatcher.sv
// Bench for spike_dispatcher: queue-based timestep model checked every cycle, directed literal scenarios, random traffic.
`timescale 1ns/1ps
module tb_spike_dispatcher;
  localparam int N  = 10;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] base_address;
  logic          timestep_done;
  logic [N-1:0]  spikes_in;
  logic          busy;
  logic          overrun;
  logic [1:0]    fsm_state;
`ifdef SPIKE_DISPATCH_COUNT_EN
  logic [15:0]   spike_count;
`endif

  spike_dispatcher_if #(.number_of_address_bits(AW)) bus ();

  spike_dispatcher #(
    .number_of_units(N),
    .number_of_address_bits(AW)
  ) dut (
    .CLK(clk),
    .reset(reset),
    .base_address(base_address),
    .timestep_done(timestep_done),
    .spikes_in(spikes_in),
    .bus(bus),
    .busy(busy),
    .overrun(overrun),
    .fsm_state(fsm_state)
`ifdef SPIKE_DISPATCH_COUNT_EN
    ,
    .spike_count(spike_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // reference model: addresses still owed this timestep, clear pulse, sticky overrun, count
  logic [AW-1:0] m_q[$];
  bit            m_clr = 1'b0;
  bit            m_ovr = 1'b0;
  int            m_cnt = 0;
  bit            checking = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_clr = 1'b0;
      m_ovr = 1'b0;
      m_cnt = 0;
    end else if (m_clr) begin
      m_clr = 1'b0;
      if (timestep_done) m_ovr = 1'b1;
    end else if (m_q.size() > 0) begin
      if (timestep_done) m_ovr = 1'b1;
      if (bus.spike_ready) begin
        void'(m_q.pop_front());
        if (m_cnt < 65535) m_cnt++;
        if (m_q.size() == 0) m_clr = 1'b1;
      end
    end else if (timestep_done) begin
      m_cnt = 0;
      for (int i = 0; i < N; i++)
        if (spikes_in[i]) m_q.push_back(AW'(int'(base_address) + i));
      if (m_q.size() == 0) m_clr = 1'b1;
    end
  end

  // scoreboard: observed transfers and clear pulses
  logic [AW-1:0] got_q[$];
  logic [AW-1:0] exp_q[$];
  int            clears = 0;

  always @(negedge clk) begin
    if (checking) begin
      check("spike_valid", bus.spike_valid, m_q.size() > 0);
      if (m_q.size() > 0) check("source_address", bus.source_address, m_q[0]);
      check("clear", bus.clear, m_clr);
      check("busy", busy, (m_q.size() > 0) || m_clr);
      check("overrun", overrun, m_ovr);
`ifdef SPIKE_DISPATCH_COUNT_EN
      check("spike_count", spike_count, m_cnt[15:0]);
`endif
      if (bus.spike_valid && bus.spike_ready) got_q.push_back(bus.source_address);
      if (bus.clear) clears++;
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] s, input logic [AW-1:0] b);
    timestep_done = 1'b1;
    spikes_in     = s;
    base_address  = b;
    step();
    timestep_done = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [AW-1:0] a,
                            input logic c, input logic b);
    check({tag, ".valid"}, bus.spike_valid, v);
    if (v) check({tag, ".addr"}, bus.source_address, a);
    check({tag, ".clear"}, bus.clear, c);
    check({tag, ".busy"}, busy, b);
  endtask

  task automatic check_seq(input string tag);
    check({tag, ".count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check({tag, ".seq"}, got_q[i], exp_q[i]);
    got_q.delete();
  endtask

  function automatic logic [N-1:0] rand_spikes();
    case ($urandom_range(0, 4))
      0:       rand_spikes = '0;
      1:       rand_spikes = '1;
      2:       rand_spikes = N'(1) << $urandom_range(0, N - 1);
      default: rand_spikes = N'($urandom);
    endcase
  endfunction

  initial begin
    int ready_pct;
    reset           = 1'b1;
    timestep_done   = 1'b0;
    spikes_in       = '0;
    base_address    = '0;
    bus.spike_ready = 1'b0;
    step();
    checking = 1'b1;
    step();
    expect_out("reset", 1'b0, '0, 1'b0, 1'b0);
    check("reset.addr", bus.source_address, 0);
    check("reset.overrun", overrun, 0);
    reset = 1'b0;
    step();

    // three spikes, ready high: back-to-back addresses then one clear
    bus.spike_ready = 1'b1;
    got_q.delete();
    clears = 0;
    pulse(10'b0000100101, 12'h100);
    expect_out("s1.c1", 1'b1, 12'h100, 1'b0, 1'b1);
    step();
    expect_out("s1.c2", 1'b1, 12'h102, 1'b0, 1'b1);
    step();
    expect_out("s1.c3", 1'b1, 12'h105, 1'b0, 1'b1);
    step();
    expect_out("s1.clr", 1'b0, '0, 1'b1, 1'b1);
`ifdef SPIKE_DISPATCH_COUNT_EN
    check("s1.spike_count", spike_count, 3);
`endif
    step();
    expect_out("s1.idle", 1'b0, '0, 1'b0, 1'b0);
    exp_q = '{12'h100, 12'h102, 12'h105};
    check_seq("s1");
    check("s1.clears", clears, 1);

    // empty timestep still closes with clear
    pulse('0, 12'h200);
    expect_out("s2.clr", 1'b0, '0, 1'b1, 1'b1);
    step();
    expect_out("s2.idle", 1'b0, '0, 1'b0, 1'b0);
    check("s2.overrun", overrun, 0);
    exp_q.delete();
    check_seq("s2");

    // back-pressure and address wrap
    bus.spike_ready = 1'b0;
    pulse(10'b1000000001, 12'hFFF);
    expect_out("s3.h1", 1'b1, 12'hFFF, 1'b0, 1'b1);
    step();
    expect_out("s3.h2", 1'b1, 12'hFFF, 1'b0, 1'b1);
    step();
    expect_out("s3.h3", 1'b1, 12'hFFF, 1'b0, 1'b1);
    step();
    bus.spike_ready = 1'b1;
    expect_out("s3.h4", 1'b1, 12'hFFF, 1'b0, 1'b1);
    step();
    expect_out("s3.wrap", 1'b1, 12'h008, 1'b0, 1'b1);
    step();
    expect_out("s3.clr", 1'b0, '0, 1'b1, 1'b1);
    step();
    exp_q = '{12'hFFF, 12'h008};
    check_seq("s3");

    // timestep_done while sending: ignored apart from overrun
    pulse(10'b0000100101, 12'h100);
    step();
    timestep_done = 1'b1;
    spikes_in     = '1;
    base_address  = 12'h000;
    expect_out("s4.c2", 1'b1, 12'h102, 1'b0, 1'b1);
    step();
    timestep_done = 1'b0;
    expect_out("s4.c3", 1'b1, 12'h105, 1'b0, 1'b1);
    check("s4.overrun", overrun, 1);
    step();
    expect_out("s4.clr", 1'b0, '0, 1'b1, 1'b1);
    step();
    expect_out("s4.idle", 1'b0, '0, 1'b0, 1'b0);
    check("s4.overrun_sticky", overrun, 1);
    exp_q = '{12'h100, 12'h102, 12'h105};
    check_seq("s4");

    // reset mid-send with two spikes left: nothing more, no clear
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("s5.overrun_cleared", overrun, 0);
    pulse(10'b0000001111, 12'h000);
    step();
    step();
    expect_out("s5.pre", 1'b1, 12'h002, 1'b0, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    clears = 0;
    expect_out("s5.rst", 1'b0, '0, 1'b0, 1'b0);
    check("s5.rst.addr", bus.source_address, 0);
    check("s5.rst.overrun", overrun, 0);
    step();
    step();
    step();
    check("s5.no_clear", clears, 0);
    got_q.delete();
    pulse(10'b1100000000, 12'h010);
    step();
    step();
    step();
    exp_q = '{12'h018, 12'h019};
    check_seq("s5");
    check("s5.clears", clears, 1);

    // all ten units fire: clear lands ten cycles after the first spike
    pulse('1, 12'h000);
    for (int i = 0; i < 10; i++) step();
    expect_out("s6.clr", 1'b0, '0, 1'b1, 1'b1);
`ifdef SPIKE_DISPATCH_COUNT_EN
    check("s6.spike_count", spike_count, 10);
`endif
    step();
    pulse(10'b0000000001, 12'h000);
    expect_out("s6.next", 1'b1, 12'h000, 1'b0, 1'b1);
`ifdef SPIKE_DISPATCH_COUNT_EN
    check("s6.count_restart", spike_count, 0);
`endif
    step();
    step();
    got_q.delete();

    // random traffic: random ready duty, overlapping done pulses, rare resets
    for (int t = 0; t < 250; t++) begin
      ready_pct = $urandom_range(20, 100);
      for (int c = 0; c < 30; c++) begin
        reset           = ($urandom_range(0, 79) == 0);
        timestep_done   = ($urandom_range(0, 7) == 0);
        spikes_in       = rand_spikes();
        base_address    = ($urandom_range(0, 3) == 0) ? AW'(12'hFF8 + $urandom_range(0, 7))
                                                      : AW'($urandom);
        bus.spike_ready = ($urandom_range(1, 100) <= ready_pct);
        step();
      end
    end

    // drain with a bounded budget
    reset           = 1'b0;
    timestep_done   = 1'b0;
    bus.spike_ready = 1'b1;
    for (int c = 0; c < 20; c++) step();
    check("drain_idle", busy, 0);
    checking = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
